// File: rtl/bp_fe_bp_update_queue.sv
// In-flight prediction tracker for bp_fe_bp_gselect.
// Records each lookup (BHT index and predicted direction) in program order.
// When the oldest branch resolves, its entry is popped and the predictor's
// training port is driven on the following cycle. Mispredictions are counted
// with a saturating counter.
module bp_fe_bp_update_queue #(
  parameter int unsigned bht_idx_width_p = 9,
  parameter int unsigned els_p           = 8,
  parameter int unsigned cnt_width_p     = 16,
  localparam int unsigned ptr_w          = $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       pred_v_i,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  input  logic                       pred_taken_i,
  output logic                       pred_ready_o,
  input  logic                       resolve_v_i,
  input  logic                       resolve_taken_i,
  output logic                       resolve_ready_o,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic [ptr_w:0]             count_o,
  output logic [cnt_width_p-1:0]     mispredict_cnt_o
);

  logic [ptr_w-1:0]           rd_ptr_r;
  logic [ptr_w-1:0]           wr_ptr_r;
  logic [bht_idx_width_p-1:0] idx_mem   [els_p];
  logic                       taken_mem [els_p];

  logic                       push_acc;
  logic                       pop_acc;
  logic [bht_idx_width_p-1:0] head_idx;
  logic                       head_taken;
  logic                       head_correct;

  assign pred_ready_o    = (count_o != (ptr_w+1)'(els_p));
  assign resolve_ready_o = (count_o != '0);

  // A push in the flush cycle is discarded; a pop in the flush cycle still trains.
  assign push_acc     = pred_v_i & pred_ready_o & ~flush_i;
  assign pop_acc      = resolve_v_i & resolve_ready_o;
  assign head_idx     = idx_mem[rd_ptr_r];
  assign head_taken   = taken_mem[rd_ptr_r];
  assign head_correct = (resolve_taken_i == head_taken);

  // Entry storage; contents are don't-care out of reset.
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      idx_mem[wr_ptr_r]   <= pred_idx_i;
      taken_mem[wr_ptr_r] <= pred_taken_i;
    end
  end

  // Pointer and occupancy bookkeeping; flush collapses the queue onto wr_ptr.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_o  <= '0;
    end else if (flush_i) begin
      rd_ptr_r <= wr_ptr_r;
      count_o  <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr_r <= wr_ptr_r + ptr_w'(1);
      end
      if (pop_acc) begin
        rd_ptr_r <= rd_ptr_r + ptr_w'(1);
      end
      if (push_acc && !pop_acc) begin
        count_o <= count_o + (ptr_w+1)'(1);
      end else if (pop_acc && !push_acc) begin
        count_o <= count_o - (ptr_w+1)'(1);
      end
    end
  end

  // Training port: one-cycle pulse after each accepted pop; index/correct hold otherwise.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_v_o     <= 1'b0;
      idx_w_o   <= '0;
      correct_o <= 1'b0;
    end else begin
      w_v_o <= pop_acc;
      if (pop_acc) begin
        idx_w_o   <= head_idx;
        correct_o <= head_correct;
      end
    end
  end

  // Saturating mispredict counter; unaffected by flush.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mispredict_cnt_o <= '0;
    end else if (pop_acc && !head_correct && (mispredict_cnt_o != '1)) begin
      mispredict_cnt_o <= mispredict_cnt_o + cnt_width_p'(1);
    end
  end

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// Bench for bp_fe_bp_update_queue: a reference queue model produces expected
// training results into a scoreboard when a pop is driven; they are popped and
// compared when the DUT raises w_v_o. A second instance uses a 2-bit
// mispredict counter to exercise saturation.
module tb_bp_fe_bp_update_queue;

  logic       clk;
  logic       reset_n_i;
  logic       pred_v_i;
  logic [8:0] pred_idx_i;
  logic       pred_taken_i;
  logic       resolve_v_i;
  logic       resolve_taken_i;
  logic       flush_i;

  logic        pred_ready_o, resolve_ready_o, w_v_o, correct_o;
  logic [8:0]  idx_w_o;
  logic [3:0]  count_o;
  logic [15:0] mispredict_cnt_o;

  logic        pred_ready2, resolve_ready2, w_v2, correct2;
  logic [8:0]  idx_w2;
  logic [3:0]  count2;
  logic [1:0]  mcnt2;

  bp_fe_bp_update_queue #(.bht_idx_width_p(9), .els_p(8), .cnt_width_p(16)) u_dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .pred_v_i(pred_v_i), .pred_idx_i(pred_idx_i), .pred_taken_i(pred_taken_i),
    .pred_ready_o(pred_ready_o),
    .resolve_v_i(resolve_v_i), .resolve_taken_i(resolve_taken_i),
    .resolve_ready_o(resolve_ready_o), .flush_i(flush_i),
    .w_v_o(w_v_o), .idx_w_o(idx_w_o), .correct_o(correct_o),
    .count_o(count_o), .mispredict_cnt_o(mispredict_cnt_o)
  );

  bp_fe_bp_update_queue #(.bht_idx_width_p(9), .els_p(8), .cnt_width_p(2)) u_dut_c2 (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .pred_v_i(pred_v_i), .pred_idx_i(pred_idx_i), .pred_taken_i(pred_taken_i),
    .pred_ready_o(pred_ready2),
    .resolve_v_i(resolve_v_i), .resolve_taken_i(resolve_taken_i),
    .resolve_ready_o(resolve_ready2), .flush_i(flush_i),
    .w_v_o(w_v2), .idx_w_o(idx_w2), .correct_o(correct2),
    .count_o(count2), .mispredict_cnt_o(mcnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] idx;
    logic       tk;
  } ent_t;

  typedef struct {
    logic [8:0] idx;
    logic       corr;
  } exp_t;

  ent_t        mq[$];
  exp_t        exp_q[$];
  logic [8:0]  last_idx;
  logic        last_corr;
  int unsigned mcnt16;
  int unsigned mcnt_2;
  int          n_cmp;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    last_idx  = '0;
    last_corr = 1'b0;
    mcnt16    = 0;
    mcnt_2    = 0;
  endtask

  task automatic check_status();
    check("count", 32'(count_o), 32'(mq.size()));
    check("pred_ready", 32'(pred_ready_o), 32'(mq.size() != 8));
    check("resolve_ready", 32'(resolve_ready_o), 32'(mq.size() != 0));
    check("mcnt16", 32'(mispredict_cnt_o), mcnt16);
    check("mcnt2", 32'(mcnt2), mcnt_2);
    check("count_c2", 32'(count2), 32'(mq.size()));
  endtask

  // Drive one cycle of stimulus from a negedge, update the model, then check
  // the registered outputs at the following negedge.
  task automatic drive(input logic pv, input logic [8:0] pidx, input logic ptk,
                       input logic rv, input logic rtk, input logic fl);
    logic push_ok, pop_ok;
    ent_t h;
    exp_t e;
    pred_v_i        = pv;
    pred_idx_i      = pidx;
    pred_taken_i    = ptk;
    resolve_v_i     = rv;
    resolve_taken_i = rtk;
    flush_i         = fl;
    push_ok = pv && (mq.size() < 8) && !fl;
    pop_ok  = rv && (mq.size() > 0);
    if (pop_ok) begin
      h      = mq.pop_front();
      e.idx  = h.idx;
      e.corr = (rtk == h.tk);
      exp_q.push_back(e);
      if (!e.corr) begin
        if (mcnt16 < 16'hFFFF) mcnt16++;
        if (mcnt_2 < 3) mcnt_2++;
      end
    end
    if (fl) mq.delete();
    if (push_ok) begin
      h.idx = pidx;
      h.tk  = ptk;
      mq.push_back(h);
    end
    @(posedge clk);
    @(negedge clk);
    check("w_v", 32'(w_v_o), 32'(pop_ok));
    if (w_v_o) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("idx_w", 32'(idx_w_o), 32'(e.idx));
        check("correct", 32'(correct_o), 32'(e.corr));
        last_idx  = e.idx;
        last_corr = e.corr;
      end
    end else begin
      check("idx_hold", 32'(idx_w_o), 32'(last_idx));
      check("corr_hold", 32'(correct_o), 32'(last_corr));
    end
    check_status();
  endtask

  task automatic idle();
    drive(1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [8:0] idx, input logic tk);
    drive(1'b1, idx, tk, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop(input logic tk);
    drive(1'b0, 9'h0, 1'b0, 1'b1, tk, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_w_v"}, 32'(w_v_o), 32'd0);
    check({tag, "_idx_w"}, 32'(idx_w_o), 32'd0);
    check({tag, "_correct"}, 32'(correct_o), 32'd0);
    check({tag, "_count"}, 32'(count_o), 32'd0);
    check({tag, "_mcnt"}, 32'(mispredict_cnt_o), 32'd0);
    check({tag, "_mcnt2"}, 32'(mcnt2), 32'd0);
    check({tag, "_pred_ready"}, 32'(pred_ready_o), 32'd1);
    check({tag, "_resolve_ready"}, 32'(resolve_ready_o), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    reset_n_i = 1'b0;
    pred_v_i = 1'b0; pred_idx_i = '0; pred_taken_i = 1'b0;
    resolve_v_i = 1'b0; resolve_taken_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset_n_i = 1'b1;

    // 1: idle, then resolve on an empty queue
    idle();
    drive(1'b0, 9'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();

    // 2: single push and correct resolve
    push(9'h005, 1'b1);
    pop(1'b1);
    idle();

    // 3: three in-order entries, one mispredict
    push(9'h1A0, 1'b0);
    push(9'h011, 1'b1);
    push(9'h0FF, 1'b0);
    pop(1'b1);
    pop(1'b1);
    pop(1'b0);
    idle();

    // 4: fill to capacity, drop a push while full, push+pop while full
    for (int i = 0; i < 8; i++) push(9'(9'h040 + i), i[0]);
    push(9'h1FF, 1'b1);
    drive(1'b1, 9'h1EE, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) pop(1'b0);
    idle();

    // 5: flush with a same-cycle resolve, then wrap-around traffic
    push(9'h101, 1'b1);
    push(9'h102, 1'b0);
    push(9'h103, 1'b1);
    drive(1'b1, 9'h104, 1'b1, 1'b1, 1'b1, 1'b1);
    pop(1'b1);
    pop(1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
            1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end
    pop(1'b0);
    idle();

    // 6: drive the 2-bit counter into saturation
    for (int i = 0; i < 5; i++) begin
      push(9'(9'h0A0 + i), 1'b1);
      pop(1'b0);
    end
    idle();

    // 6: asynchronous reset in the middle of traffic
    push(9'h0C3, 1'b1);
    push(9'h0C4, 1'b0);
    pop(1'b0);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();
    pred_v_i = 1'b0; resolve_v_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    reset_n_i = 1'b1;
    idle();
    push(9'h033, 1'b0);
    pop(1'b0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
